// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer: XLEN width
// codes, FSM state encoding, result-source codes and the control bundle.
package hazard_stall_ctrl_pkg;

    // Width codes; data width is 1 << (code + 4).
    localparam logic [1:0] XLEN_16b  = 2'd0;
    localparam logic [1:0] XLEN_32b  = 2'd1;
    localparam logic [1:0] XLEN_64b  = 2'd2;
    localparam logic [1:0] XLEN_128b = 2'd3;

    // EX result source selecting the data-memory read path.
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // Width of the memory wait counter; covers MEM_TIMEOUT up to 255.
    localparam int WAIT_W = 8;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_TRAP_DRAIN = 2'd2
    } state_e;

    // Every combinational output of the sequencer, bundled so that a
    // whole decision can be built and returned in one value.
    typedef struct packed {
        logic en_f;
        logic en_d;
        logic en_e;
        logic en_m;
        logic en_w;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic pc_trap_sel;
        logic mem_fault;
    } ctrl_t;

    // Free-flowing pipeline: every stage enabled, nothing flushed.
    localparam ctrl_t CTRL_FLOW   = ctrl_t'(10'b11111_000_00);
    // Whole pipeline frozen while data memory is outstanding.
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(10'b00000_000_00);

    // Data width in bits for a given XLEN code.
    function automatic int xlen_bits(input logic [1:0] code);
        return 32'sd1 <<< (int'(code) + 4);
    endfunction

    // Redirect and load-use resolution used both in RUN and on the cycle
    // a memory wait completes. A taken branch squashes the younger
    // instructions anyway, so it wins over the load-use bubble.
    function automatic ctrl_t ctrl_resolve(input logic pc_src, input logic lu);
        ctrl_t c;
        c = CTRL_FLOW;
        if (pc_src) begin
            c.flush_d = 1'b1;
            c.flush_e = 1'b1;
        end else if (lu) begin
            c.en_f    = 1'b0;
            c.en_d    = 1'b0;
            c.flush_e = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Load-use hazard compare: the instruction in EX is a load whose
// destination is read by the instruction sitting in ID.
module hazard_stall_ctrl_hazard_detect
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [4:0] i_rs1_d,
    input  logic [4:0] i_rs2_d,
    input  logic [4:0] i_rd_e,
    input  logic [1:0] i_result_src_e,
    input  logic       i_reg_wr_e,
    output logic       o_lu
);

    logic is_load_e;
    logic rd_live_e;
    logic src_match_d;

    assign is_load_e   = i_reg_wr_e && (i_result_src_e == RESULT_SRC_LOAD);
    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign rd_live_e   = (i_rd_e != 5'd0);
    assign src_match_d = (i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d);

    assign o_lu = is_load_e && rd_live_e && src_match_d;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central pipeline sequencer: per-stage enables and flushes for load-use
// bubbles, branch redirects, trap/mret redirects and multi-cycle data
// memory accesses, plus a saturating stall-cycle performance counter.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter logic [1:0] XLEN        = XLEN_64b,
    parameter int          MEM_TIMEOUT = 64,
    parameter int          CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_rs1_d,
    input  logic [4:0]       i_rs2_d,
    input  logic [4:0]       i_rd_e,
    input  logic [1:0]       i_result_src_e,
    input  logic             i_reg_wr_e,
    input  logic             i_pc_src_e,
    input  logic             i_dmem_req_m,
    input  logic             i_dmem_ready,
    input  logic             i_trap_m,
    input  logic             i_mret_m,
    output logic             o_en_f,
    output logic             o_en_d,
    output logic             o_en_e,
    output logic             o_en_m,
    output logic             o_en_w,
    output logic             o_flush_d,
    output logic             o_flush_e,
    output logic             o_flush_m,
    output logic             o_pc_trap_sel,
    output logic             o_mem_fault,
    output logic [CNT_W-1:0] o_stall_cnt
);

    // Elaboration-time parameter sanity.
    if ((CNT_W < 1) || (CNT_W > xlen_bits(XLEN))) begin : g_bad_cnt_w
        $error("hazard_stall_ctrl: CNT_W must lie between 1 and the data width");
    end
    if ((MEM_TIMEOUT < 2) || (MEM_TIMEOUT > 255)) begin : g_bad_timeout
        $error("hazard_stall_ctrl: MEM_TIMEOUT must lie between 2 and 255");
    end

    // Wait counter value on the last wait cycle before the timeout fires:
    // the entry cycle in RUN counts as wait cycle 1 and loads the counter
    // with 1, so wait cycle N sees a counter of N-1.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    // Saturating increment for the stall performance counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    ctrl_t             ctrl;
    logic              lu;
    logic              trap_or_mret;
    logic              mem_miss;

    hazard_stall_ctrl_hazard_detect u_hazard_detect (
        .i_rs1_d        (i_rs1_d),
        .i_rs2_d        (i_rs2_d),
        .i_rd_e         (i_rd_e),
        .i_result_src_e (i_result_src_e),
        .i_reg_wr_e     (i_reg_wr_e),
        .o_lu           (lu)
    );

    assign trap_or_mret = i_trap_m || i_mret_m;
    assign mem_miss     = i_dmem_req_m && !i_dmem_ready;

    // Next-state and zero-latency control outputs from state and inputs.
    always_comb begin
        ctrl    = CTRL_FLOW;
        state_d = state_q;
        wait_d  = wait_q;

        if (!i_rst) begin
            unique case (state_q)
                ST_RUN: begin
                    if (trap_or_mret) begin
                        // Redirect to the trap/mret target; any memory
                        // request from the faulting instruction is dropped.
                        ctrl.pc_trap_sel = 1'b1;
                        ctrl.flush_d     = 1'b1;
                        ctrl.flush_e     = 1'b1;
                        ctrl.flush_m     = 1'b1;
                        state_d          = ST_TRAP_DRAIN;
                    end else if (mem_miss) begin
                        ctrl    = CTRL_FREEZE;
                        state_d = ST_MEM_WAIT;
                        wait_d  = WAIT_W'(1);
                    end else begin
                        ctrl = ctrl_resolve(i_pc_src_e, lu);
                    end
                end

                ST_MEM_WAIT: begin
                    // MEM is frozen here, so a trap flag is stale and ignored.
                    if (i_dmem_ready) begin
                        ctrl    = ctrl_resolve(i_pc_src_e, lu);
                        state_d = ST_RUN;
                        wait_d  = '0;
                    end else if (wait_q >= WAIT_LAST) begin
                        // Give up on the access and let the pipeline move.
                        ctrl.mem_fault = 1'b1;
                        state_d        = ST_RUN;
                        wait_d         = '0;
                    end else begin
                        ctrl   = CTRL_FREEZE;
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end

                ST_TRAP_DRAIN: begin
                    // Squash the two wrong-path instructions fetched while
                    // the redirected PC was still propagating.
                    ctrl.flush_d = 1'b1;
                    ctrl.flush_e = 1'b1;
                    state_d      = ST_RUN;
                end

                default: begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end
            endcase
        end
    end

    assign stall_cnt_d = ctrl.en_f ? stall_cnt_q : sat_inc(stall_cnt_q);

    // State, wait counter and stall counter registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_en_f        = ctrl.en_f;
    assign o_en_d        = ctrl.en_d;
    assign o_en_e        = ctrl.en_e;
    assign o_en_m        = ctrl.en_m;
    assign o_en_w        = ctrl.en_w;
    assign o_flush_d     = ctrl.flush_d;
    assign o_flush_e     = ctrl.flush_e;
    assign o_flush_m     = ctrl.flush_m;
    assign o_pc_trap_sel = ctrl.pc_trap_sel;
    assign o_mem_fault   = ctrl.mem_fault;
    assign o_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_hazard_stall_ctrl;

    localparam int MEM_TO  = 4;
    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [4:0]       rs1_d, rs2_d, rd_e;
    logic [1:0]       result_src_e;
    logic             reg_wr_e, pc_src_e, dmem_req_m, dmem_ready, trap_m, mret_m;
    logic             en_f, en_d, en_e, en_m, en_w;
    logic             flush_d, flush_e, flush_m, pc_trap_sel, mem_fault;
    logic [CNT_W-1:0] stall_cnt;

    hazard_stall_ctrl #(
        .MEM_TIMEOUT (MEM_TO),
        .CNT_W       (CNT_W)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_rs1_d        (rs1_d),
        .i_rs2_d        (rs2_d),
        .i_rd_e         (rd_e),
        .i_result_src_e (result_src_e),
        .i_reg_wr_e     (reg_wr_e),
        .i_pc_src_e     (pc_src_e),
        .i_dmem_req_m   (dmem_req_m),
        .i_dmem_ready   (dmem_ready),
        .i_trap_m       (trap_m),
        .i_mret_m       (mret_m),
        .o_en_f         (en_f),
        .o_en_d         (en_d),
        .o_en_e         (en_e),
        .o_en_m         (en_m),
        .o_en_w         (en_w),
        .o_flush_d      (flush_d),
        .o_flush_e      (flush_e),
        .o_flush_m      (flush_m),
        .o_pc_trap_sel  (pc_trap_sel),
        .o_mem_fault    (mem_fault),
        .o_stall_cnt    (stall_cnt)
    );

    // Bit order: 9 en_f, 8 en_d, 7 en_e, 6 en_m, 5 en_w,
    //            4 flush_d, 3 flush_e, 2 flush_m, 1 pc_trap_sel, 0 mem_fault
    logic [9:0] obs;
    assign obs = {en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, flush_m, pc_trap_sel, mem_fault};

    int errors = 0;
    int checks = 0;

    // Reference model: number of cycles already spent stalled on the current
    // memory access (0 = none outstanding), a pending post-trap drain cycle,
    // and the expected stall count.
    int m_waited = 0;
    bit m_drain  = 1'b0;
    int m_cnt    = 0;

    logic [9:0] last_obs;

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, compare outputs
    // against the model, then advance the model across the rising edge.
    task automatic step(input logic r, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic [1:0] src, input logic rw,
                        input logic pcs, input logic req, input logic rdy,
                        input logic trp, input logic mrt, input string tag);
        logic [9:0] exp;
        logic [9:0] care;
        logic       lu;
        @(negedge clk);
        rst = r; rs1_d = a; rs2_d = b; rd_e = d; result_src_e = src; reg_wr_e = rw;
        pc_src_e = pcs; dmem_req_m = req; dmem_ready = rdy; trap_m = trp; mret_m = mrt;
        #1;
        lu   = rw && (src == 2'b01) && (d != 5'd0) && ((d == a) || (d == b));
        exp  = 10'b11111_000_00;
        care = 10'b11111_111_11;
        if (r) begin
            exp = 10'b11111_000_00;
        end else if (m_drain) begin
            exp  = 10'b11111_110_00;
            care = 10'b10001_111_11;
        end else if (m_waited > 0 && !rdy) begin
            if (m_waited + 1 == MEM_TO) exp = 10'b11111_000_01;
            else                        exp = 10'b00000_000_00;
        end else if (m_waited == 0 && (trp || mrt)) begin
            exp = 10'b11111_111_10;
        end else if (m_waited == 0 && req && !rdy) begin
            exp = 10'b00000_000_00;
        end else if (pcs) begin
            exp = 10'b11111_110_00;
        end else if (lu) begin
            exp = 10'b00111_010_00;
        end
        last_obs = obs;
        checks++;
        assert ((obs & care) === (exp & care)) else begin
            errors++;
            $error("FAIL %s ctrl: got %b, expected %b (mask %b)", tag, obs & care, exp & care, care);
        end
        checks++;
        assert (stall_cnt === CNT_W'(m_cnt)) else begin
            errors++;
            $error("FAIL %s stall_cnt: got %0d, expected %0d", tag, stall_cnt, m_cnt);
        end
        @(posedge clk);
        if (r) begin
            m_waited = 0;
            m_drain  = 1'b0;
            m_cnt    = 0;
        end else begin
            if (!exp[9] && m_cnt < CNT_MAX) m_cnt++;
            if (m_drain) begin
                m_drain = 1'b0;
            end else if (m_waited > 0) begin
                if (rdy || (m_waited + 1 == MEM_TO)) m_waited = 0;
                else                                 m_waited++;
            end else if (trp || mrt) begin
                m_drain = 1'b1;
            end else if (req && !rdy) begin
                m_waited = 1;
            end
        end
    endtask

    task automatic idle(input string tag);
        step(1'b0, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        logic       r, rw, pcs, req, rdy, trp, mrt;
        logic [4:0] a, b, d;
        logic [1:0] src;

        rst = 1'b1; rs1_d = '0; rs2_d = '0; rd_e = '0; result_src_e = '0; reg_wr_e = 1'b0;
        pc_src_e = 1'b0; dmem_req_m = 1'b0; dmem_ready = 1'b0; trap_m = 1'b0; mret_m = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held: free-flowing outputs, counter cleared.
        step(1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "rst_hold");
        #1 chk("rst_cnt", int'(stall_cnt), 0);

        // Load-use on rs1.
        step(1'b0, 5'd5, 5'd7, 5'd5, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lu");
        chk("lu_en_f", int'(last_obs[9]), 0);
        chk("lu_flush_e", int'(last_obs[3]), 1);
        #1 chk("lu_cnt", int'(stall_cnt), 1);

        // Same load targeting x0: no stall.
        step(1'b0, 5'd0, 5'd7, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lu_rd0");
        chk("lu_rd0_en_f", int'(last_obs[9]), 1);

        // Branch together with load-use: branch wins.
        step(1'b0, 5'd5, 5'd7, 5'd5, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "br_lu");
        chk("br_lu_flush_d", int'(last_obs[4]), 1);
        #1 chk("br_lu_cnt", int'(stall_cnt), 1);

        // Memory wait: three frozen cycles, ready on the fourth.
        step(1'b0, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "mw_entry");
        step(1'b0, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "mw_wait1");
        step(1'b0, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "mw_wait2");
        step(1'b0, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "mw_ready");
        chk("mw_ready_en_m", int'(last_obs[6]), 1);
        #1 chk("mw_cnt", int'(stall_cnt), 4);
        idle("mw_after");

        // Timeout: fault pulse on the fourth wait cycle.
        step(1'b0, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "to_entry");
        step(1'b0, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "to_wait1");
        step(1'b0, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "to_wait2");
        step(1'b0, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "to_fault");
        chk("to_fault_pulse", int'(last_obs[0]), 1);
        idle("to_after");
        chk("to_after_pulse", int'(last_obs[0]), 0);
        #1 chk("to_cnt", int'(stall_cnt), 7);

        // Trap with a simultaneous memory miss: redirect, drain, no wait.
        step(1'b0, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "trap");
        chk("trap_sel", int'(last_obs[1]), 1);
        step(1'b0, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "trap_drain");
        chk("drain_flush_e", int'(last_obs[3]), 1);
        chk("drain_sel", int'(last_obs[1]), 0);
        idle("trap_after");
        #1 chk("trap_cnt", int'(stall_cnt), 7);

        // Mret takes the same path.
        step(1'b0, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "mret");
        idle("mret_drain");
        idle("mret_after");

        // Reset on the second MEM_WAIT cycle abandons the access.
        step(1'b0, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rw_entry");
        step(1'b0, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rw_wait1");
        step(1'b1, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rw_rst");
        #1 chk("rw_cnt", int'(stall_cnt), 0);
        step(1'b0, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "rw_after");
        chk("rw_after_en_f", int'(last_obs[9]), 1);
        chk("rw_after_fault", int'(last_obs[0]), 0);

        // Saturation of the stall counter.
        for (int i = 0; i < 40; i++)
            step(1'b0, 5'd9, 5'd5, 5'd5, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sat");
        #1 chk("sat_cnt", int'(stall_cnt), CNT_MAX);
        idle("sat_after");

        // Randomized traffic; small register range keeps hazards frequent.
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 49) == 0);
            a   = 5'($urandom_range(0, 3));
            b   = 5'($urandom_range(0, 3));
            d   = 5'($urandom_range(0, 3));
            src = 2'($urandom_range(0, 3));
            rw  = 1'($urandom_range(0, 1));
            pcs = ($urandom_range(0, 5) == 0);
            req = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            trp = ($urandom_range(0, 15) == 0);
            mrt = ($urandom_range(0, 19) == 0);
            step(r, a, b, d, src, rw, pcs, req, rdy, trp, mrt, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
